uart_receiver: RTL

- Receive half of the ADC board's serial link: 8N1 UART frames arrive from the host COM port and are written one byte at a time into the downstream byte FIFO.
- Converts the asynchronous `rx` line into bytes using a double-flop synchronizer and mid-bit sampling.
- Drives a registered flow-control line back to the host so the FIFO never overflows.
- Sits in the UART clock domain beside the transmitter and shares its bit-period parameter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 43 ++++
 rtl/uart_receiver.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, line-level constants and the default bit period.
// The vote helper is only referenced when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic FLOW_STOP = 1'b1;

    // 100 MHz / 921600 baud
    localparam int CLKS_PER_BIT_DEFAULT = 108;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin; with UART_RX_MAJORITY_EN it also keeps a
// 3-tap history and presents a 2-of-3 vote as the bit sample.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_sync,
    output logic sample
);

    logic rx_meta;

    // Both stages reset to the idle line level so no false start bit follows reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= STOP_BIT;
            rx_sync <= STOP_BIT;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] rx_hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_hist <= {2{STOP_BIT}};
        end else begin
            rx_hist <= {rx_hist[0], rx_sync};
        end
    end

    // Decision is taken one clock after the nominal point so the vote spans c-1, c, c+1.
    assign sample = majority3(rx_sync, rx_hist[0], rx_hist[1]);
`else
    assign sample = rx_sync;
`endif

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver writing bytes into a downstream FIFO with registered flow control.
// Optional build macro UART_RX_MAJORITY_EN enables 2-of-3 majority sampling (needs CLKS_PER_BIT >= 6).
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       fifoFull,
    output logic [7:0] rxData,
    output logic       fifoWriteEnable,
    output logic       rxCtlFlow,
    output logic       frameError,
    output logic       overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif

    localparam logic [CNT_W-1:0] START_PT = CNT_W'(CLKS_PER_BIT / 2 + VOTE_LAG);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             rx_sync;
    logic             sample;
    logic             at_start_pt;
    logic             at_bit_end;
    logic             write_next;
    logic             frame_err_next;
    logic             overrun_next;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_sync (rx_sync),
        .sample  (sample)
    );

    assign at_start_pt = (cnt == START_PT);
    assign at_bit_end  = (cnt == BIT_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (rx_sync == START_BIT) state_next = START;
            START: if (at_start_pt) state_next = (sample == START_BIT) ? DATA : IDLE;
            DATA:  if (at_bit_end && bit_idx == 3'd7) state_next = STOP;
            STOP:  if (at_bit_end) state_next = (sample == STOP_BIT) ? IDLE : BREAK;
            BREAK: if (rx_sync == STOP_BIT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // fifoFull is looked at only in the cycle the stop bit is accepted; there is no retry.
    always_comb begin
        write_next     = 1'b0;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        if (state == STOP && at_bit_end) begin
            if (sample != STOP_BIT) begin
                frame_err_next = 1'b1;
            end else if (fifoFull) begin
                overrun_next = 1'b1;
            end else begin
                write_next = 1'b1;
            end
        end
    end

    // The IDLE cycle that sees the start edge counts as count 0 of the start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt     <= (rx_sync == START_BIT) ? CNT_W'(1) : '0;
                    bit_idx <= '0;
                end
                START: begin
                    cnt     <= at_start_pt ? '0 : cnt + 1'b1;
                    bit_idx <= '0;
                end
                DATA: begin
                    if (at_bit_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP:    cnt <= at_bit_end ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && at_bit_end) begin
            shift_reg <= {sample, shift_reg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxData          <= 8'h00;
            fifoWriteEnable <= 1'b0;
            frameError      <= 1'b0;
            overrun         <= 1'b0;
            rxCtlFlow       <= FLOW_STOP;
        end else begin
            fifoWriteEnable <= write_next;
            frameError      <= frame_err_next;
            overrun         <= overrun_next;
            rxCtlFlow       <= fifoFull;
            if (write_next) begin
                rxData <= shift_reg;
            end
        end
    end

endmodule
